dmem_port_arbiter: RTL and testbench

//  Shares one data-memory port (sync-read, byte-strobed) between the CPU core (M0) and the

---
 rtl/dmem_port_arbiter.sv | 97 +++++++++
 tb/tb_dmem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for a single sync-read, byte-strobed data memory port.
// M0 (core) has fixed priority; M1 is forced ahead after MAX_WAIT stalled cycles.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_strb,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_strb,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int SW = DATA_WIDTH / 8;
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    logic [7:0] wait_q, wait_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;
    logic       force_m1;
    logic       gnt0, gnt1;

    assign force_m1 = (wait_q == WAIT_LIM);
    assign gnt1     = !rst && m1_req && (!m0_req || force_m1);
    assign gnt0     = !rst && m0_req && !gnt1;
    assign m0_gnt   = gnt0;
    assign m1_gnt   = gnt1;

    // Route the granted side onto the memory port; idle drives M0 payload.
    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = 1'b0;
        mem_wstrb = '0;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        if (gnt1) begin
            mem_we    = m1_we;
            mem_wstrb = m1_we ? m1_strb : {SW{1'b0}};
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end else if (gnt0) begin
            mem_we    = m0_we;
            mem_wstrb = m0_we ? m0_strb : {SW{1'b0}};
        end
    end

    // Next-state for the starvation counter and the read-return tracker.
    always_comb begin
        wait_d     = wait_q;
        rd_pend_d  = (gnt0 | gnt1) & !mem_we;
        rd_owner_d = gnt1;
        if (!m1_req || gnt1) begin
            wait_d = 8'd0;
        end else if (wait_q != WAIT_LIM) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // State registers; async reset also drops any read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q     <= 8'd0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            wait_q     <= wait_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0_rvalid = rd_pend_q & !rd_owner_q;
    assign m1_rvalid = rd_pend_q & rd_owner_q;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter.
// Inputs change 1 unit after each edge.
module tb_dmem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst;
  logic          m0_req, m0_we;
  logic          m0_gnt, m0_rvalid;
  logic [SW-1:0] m0_strb;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we;
  logic          m1_gnt, m1_rvalid;
  logic [SW-1:0] m1_strb;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_en, mem_we;
  logic [SW-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;
  int first_gnt;

  dmem_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_WAIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we),
    .m0_strb(m0_strb),
    .m0_addr(m0_addr),
    .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we),
    .m1_strb(m1_strb),
    .m1_addr(m1_addr),
    .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < SW; b++)
          if (mem_wstrb[b])
            mem[mem_addr][b*8 +: 8] <=
              mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++)
      mem[i] = 32'h0;
    mem[10'h010] = 32'hDEADBEEF;
    mem[10'h001] = 32'h11111111;
    mem[10'h002] = 32'h22222222;
    mem[10'h003] = 32'h33333333;
    mem[10'h020] = 32'hCAFEF00D;
    mem[10'h3FF] = 32'hAABBCCDD;
    mem_rdata = '0;

    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1;
    m0_strb = 4'hF; m0_addr = '0;
    m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b1;
    m1_strb = 4'hF; m1_addr = '0;
    m1_wdata = '0;
    #2;
    chk("rst_m0_gnt", m0_gnt, 1'b0);
    chk("rst_m1_gnt", m1_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_wstrb", mem_wstrb, 4'h0);
    chk("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("rst_m1_rvalid", m1_rvalid, 1'b0);
    m0_req = 1'b0; m1_req = 1'b0;
    m0_we = 1'b0; m1_we = 1'b0;
    tick();
    rst = 1'b0;

    tick();
    m0_req = 1'b1; m0_addr = 10'h010;
    #3;
    chk("t1_m0_gnt", m0_gnt, 1'b1);
    chk("t1_mem_en", mem_en, 1'b1);
    chk("t1_rd_wstrb", mem_wstrb, 4'h0);
    tick();
    m0_req = 1'b0;
    #3;
    chk("t1_m0_rvalid", m0_rvalid, 1'b1);
    chk("t1_m0_rdata", m0_rdata,
        32'hDEADBEEF);
    chk("t1_m1_rvalid", m1_rvalid, 1'b0);

    tick();
    m0_req = 1'b1; m0_addr = 10'h001;
    m1_req = 1'b1; m1_addr = 10'h020;
    for (int c = 0; c < 10; c++) begin
      #3;
      chk("t2_m0_gnt", m0_gnt, (c != 8));
      chk("t2_m1_gnt", m1_gnt, (c == 8));
      if (c == 9) begin
        chk("t2_m1_rvalid", m1_rvalid, 1'b1);
        chk("t2_m1_rdata", m1_rdata,
            32'hCAFEF00D);
      end
      tick();
      if (c == 8) m1_req = 1'b0;
    end
    m0_req = 1'b0;
    #3;
    chk("t2_wait_clr", dut.wait_q, 8'd0);

    tick();
    m1_req = 1'b1; m1_we = 1'b1;
    m1_addr = 10'h3FF;
    m1_strb = 4'b0011;
    m1_wdata = 32'h12345678;
    #3;
    chk("t3_m1_gnt", m1_gnt, 1'b1);
    chk("t3_mem_we", mem_we, 1'b1);
    chk("t3_wstrb", mem_wstrb, 4'b0011);
    chk("t3_addr", mem_addr, 10'h3FF);
    tick();
    m1_req = 1'b0; m1_we = 1'b0;
    m0_req = 1'b1; m0_addr = 10'h3FF;
    #3;
    chk("t3_m0_gnt", m0_gnt, 1'b1);
    chk("t3_wr_no_rvalid", m1_rvalid, 1'b0);
    tick();
    m0_req = 1'b0;
    #3;
    chk("t3_m0_rvalid", m0_rvalid, 1'b1);
    chk("t3_m0_rdata", m0_rdata,
        32'hAABB5678);
    chk("t3_m1_rvalid", m1_rvalid, 1'b0);

    tick();
    m0_req = 1'b1; m0_addr = 10'h001;
    #3;
    chk("t4_c0_m0_gnt", m0_gnt, 1'b1);
    chk("t4_c0_en", mem_en, 1'b1);
    tick();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_addr = 10'h002;
    #3;
    chk("t4_c1_m1_gnt", m1_gnt, 1'b1);
    chk("t4_c1_en", mem_en, 1'b1);
    chk("t4_c1_m0_rvalid", m0_rvalid, 1'b1);
    chk("t4_c1_m1_rvalid", m1_rvalid, 1'b0);
    chk("t4_c1_rdata", m0_rdata,
        32'h11111111);
    tick();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_addr = 10'h003;
    #3;
    chk("t4_c2_m0_gnt", m0_gnt, 1'b1);
    chk("t4_c2_en", mem_en, 1'b1);
    chk("t4_c2_m1_rvalid", m1_rvalid, 1'b1);
    chk("t4_c2_m0_rvalid", m0_rvalid, 1'b0);
    chk("t4_c2_rdata", m1_rdata,
        32'h22222222);
    tick();
    m0_req = 1'b0;
    #3;
    chk("t4_c3_m0_rvalid", m0_rvalid, 1'b1);
    chk("t4_c3_rdata", m0_rdata,
        32'h33333333);
    chk("t4_c3_en", mem_en, 1'b0);

    tick();
    m1_req = 1'b1; m1_addr = 10'h002;
    #2;
    chk("t5_m1_gnt", m1_gnt, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_async_gnt", m1_gnt, 1'b0);
    chk("t5_async_en", mem_en, 1'b0);
    tick();
    m1_req = 1'b0;
    #3;
    chk("t5_m1_rvalid", m1_rvalid, 1'b0);
    rst = 1'b0;
    tick();
    m0_req = 1'b1; m0_addr = 10'h010;
    #3;
    chk("t5_resume_gnt", m0_gnt, 1'b1);
    tick();
    m0_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_drop_rvalid", m0_rvalid, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    m0_req = 1'b1; m0_addr = 10'h010;
    tick();
    m0_req = 1'b0;
    #3;
    chk("t5_after_rvalid", m0_rvalid, 1'b1);
    chk("t5_after_rdata", m0_rdata,
        32'hDEADBEEF);

    tick();
    #3;
    chk("t6_idle_en", mem_en, 1'b0);
    chk("t6_idle_wstrb", mem_wstrb, 4'h0);
    chk("t6_idle_wait", dut.wait_q, 8'd0);
    tick();
    m0_req = 1'b1; m0_addr = 10'h001;
    m1_req = 1'b1; m1_addr = 10'h002;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("t6_m1_held", m1_gnt, 1'b0);
      tick();
    end
    m1_req = 1'b0;
    tick();
    #3;
    chk("t6_wait_drop", dut.wait_q, 8'd0);
    m1_req = 1'b1;
    first_gnt = -1;
    for (int c = 0; c < 12; c++) begin
      #3;
      if (m1_gnt && first_gnt < 0)
        first_gnt = c;
      tick();
      if (first_gnt >= 0) m1_req = 1'b0;
    end
    chk("t6_full_wait", first_gnt, 8);
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
